tdm_mux_scanner: RTL and testbench

// Parametrised, registered NCH-to-1 word multiplexer. Successor to the fixed 4:1 single-bit mux tree.

---
 rtl/tdm_mux_scanner_pkg.sv | 23 ++
 rtl/tdm_mux_scanner_mux_nto1.sv | 28 ++
 rtl/tdm_mux_scanner.sv | 123 ++++++++++++
 tb/tb_tdm_mux_scanner.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_mux_scanner_pkg.sv
// Shared mode codes and FSM state encoding for the TDM word multiplexer/scanner.
package tdm_mux_scanner_pkg;

   localparam logic [1:0] MODE_MANUAL = 2'b00;
   localparam logic [1:0] MODE_SCAN   = 2'b01;
   localparam logic [1:0] MODE_HOLD   = 2'b10;

   typedef enum logic [1:0] {
      ST_MANUAL = 2'b00,
      ST_SCAN   = 2'b01,
      ST_HOLD   = 2'b10
   } state_t;

   // The unused code 2'b11 behaves as HOLD.
   function automatic state_t mode_to_state(input logic [1:0] mode);
      case (mode)
         MODE_MANUAL: return ST_MANUAL;
         MODE_SCAN:   return ST_SCAN;
         default:     return ST_HOLD;
      endcase
   endfunction

endpackage

// File: rtl/tdm_mux_scanner_mux_nto1.sv
// Combinational NCH:1 word select built as a log2(NCH)-level tree of 2:1 stages.
module mux_nto1 #(
   parameter  int WIDTH = 8,
   parameter  int NCH   = 4,
   localparam int SELW  = $clog2(NCH)
) (
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [SELW-1:0]      sel,
   output logic [WIDTH-1:0]     out_data
);

   // Level l halves the candidates using select bit l (LSB first).
   for (genvar l = 0; l < SELW; l++) begin : g_lvl
      localparam int N = NCH >> (l + 1);
      logic [WIDTH-1:0] q [N];
      for (genvar i = 0; i < N; i++) begin : g_node
         if (l == 0) begin : g_leaf
            assign q[i] = sel[0] ? in_data[(2*i+1)*WIDTH +: WIDTH]
                                 : in_data[(2*i)*WIDTH +: WIDTH];
         end else begin : g_inner
            assign q[i] = sel[l] ? g_lvl[l-1].q[2*i+1] : g_lvl[l-1].q[2*i];
         end
      end
   end

   assign out_data = g_lvl[SELW-1].q[0];

endmodule

// File: rtl/tdm_mux_scanner.sv
// Registered NCH:1 word multiplexer with MANUAL, SCAN (round-robin with dwell) and HOLD modes.
module tdm_mux_scanner
   import tdm_mux_scanner_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   parameter int SELW  = 2,
   parameter int DWELL = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       ch_en,
   input  logic [1:0]           mode,
   input  logic [SELW-1:0]      sel,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_ch,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 wrap
);

   localparam int             CNTW      = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNTW-1:0] DWELL_MAX = CNTW'(DWELL - 1);

   state_t           state, state_next;
   logic [SELW-1:0]  ptr, ptr_first, ptr_next;
   logic [CNTW-1:0]  dwell_cnt;
   logic [WIDTH-1:0] sel_word, ptr_word;
   logic             load, entry, expired, any_en, beat, skip;

   mux_nto1 #(.WIDTH(WIDTH), .NCH(NCH)) u_sel_mux (
      .in_data  (in_data),
      .sel      (sel),
      .out_data (sel_word)
   );

   mux_nto1 #(.WIDTH(WIDTH), .NCH(NCH)) u_ptr_mux (
      .in_data  (in_data),
      .sel      (ptr),
      .out_data (ptr_word)
   );

   // Priority searches; with no channel enabled ptr_next keeps ptr so the scan freezes.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      ptr_first = '0;
      ptr_next  = ptr;
      any_en    = |ch_en;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (ch_en[i]) ptr_first = SELW'(i);
      end
      // Offset NCH wraps to ptr itself, so a lone enabled channel re-selects itself.
      for (int i = NCH; i >= 1; i--) begin
         if (ch_en[ptr + SELW'(i)]) ptr_next = ptr + SELW'(i);
      end
   end

   always_comb begin
      state_next = mode_to_state(mode);
      load       = !out_valid || out_ready;
      entry      = (state_next == ST_SCAN) && (state != ST_SCAN);
      expired    = (dwell_cnt == DWELL_MAX);
      beat       = (state_next == ST_SCAN) && !entry && load && expired && ch_en[ptr];
      skip       = (state_next == ST_SCAN) && !entry && expired && !ch_en[ptr] && any_en;
   end

   // NOTE: sequential state is written with non-blocking assignments only, so every
   // register samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_MANUAL;
      else     state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         dwell_cnt <= '0;
      end else if (entry) begin
         ptr       <= ptr_first;
         dwell_cnt <= '0;
      end else if (state_next == ST_SCAN) begin
         if (beat || skip) begin
            ptr       <= ptr_next;
            dwell_cnt <= '0;
         end else if (!expired) begin
            dwell_cnt <= dwell_cnt + 1'b1;
         end
      end
   end

   // A stalled beat (valid && !ready) blocks every capture until it is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         wrap <= beat && (ptr_next <= ptr);
         if (load) begin
            case (state_next)
               ST_MANUAL: begin
                  out_data  <= sel_word;
                  out_ch    <= sel;
                  out_valid <= ch_en[sel];
               end
               ST_SCAN: begin
                  if (beat) begin
                     out_data  <= ptr_word;
                     out_ch    <= ptr;
                     out_valid <= 1'b1;
                  end else begin
                     out_valid <= 1'b0;
                  end
               end
               default: out_valid <= 1'b0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tdm_mux_scanner.sv
// Scoreboard bench for tdm_mux_scanner: directed scenarios plus random traffic against a behavioural model.
module tb_tdm_mux_scanner;

   localparam int WIDTH = 8;
   localparam int NCH   = 4;
   localparam int SELW  = 2;
   localparam int DWELL = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NCH*WIDTH-1:0] in_data;
   logic [NCH-1:0]       ch_en;
   logic [1:0]           mode;
   logic [SELW-1:0]      sel;
   logic [WIDTH-1:0]     out_data;
   logic [SELW-1:0]      out_ch;
   logic                 out_valid;
   logic                 out_ready;
   logic                 wrap;

   tdm_mux_scanner #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .DWELL(DWELL)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .ch_en     (ch_en),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      int data;
      int ch;
   } beat_t;

   beat_t exp_q[$];
   int    seen_ch[$];
   int    seen_cyc[$];
   int    wrap_cnt = 0;
   int    cyc = 0;
   bit    mon_on = 0;

   // Model state: presented beat, scan pointer, cycles spent on the current channel.
   int m_valid = 0, m_data = 0, m_ch = 0, m_wrap = 0;
   int m_ptr = 0, m_elapsed = 0, m_prev = 0;

   function automatic int word(input int k);
      return int'((in_data >> (k * WIDTH)) & ((1 << WIDTH) - 1));
   endfunction

   function automatic int lowest_en();
      for (int k = 0; k < NCH; k++) if (ch_en[k]) return k;
      return 0;
   endfunction

   function automatic int next_en(input int p);
      for (int off = 1; off <= NCH; off++) if (ch_en[(p + off) % NCH]) return (p + off) % NCH;
      return p;
   endfunction

   always @(posedge clk) begin : model
      int ms, np;
      bit ld, done;
      cyc++;
      m_wrap = 0;
      if (rst) begin
         m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0; m_elapsed = 0; m_prev = 0;
         exp_q.delete();
      end else begin
         ms   = (mode == 2'b00) ? 0 : (mode == 2'b01) ? 1 : 2;
         ld   = (m_valid == 0) || out_ready;
         if (ms == 1 && m_prev != 1) begin
            m_ptr = lowest_en();
            m_elapsed = 0;
            if (ld) m_valid = 0;
         end else if (ms == 1) begin
            done = (m_elapsed >= DWELL - 1);
            if (done && ch_en[m_ptr] && ld) begin
               m_data = word(m_ptr);
               m_ch = m_ptr;
               m_valid = 1;
               exp_q.push_back('{m_data, m_ch});
               np = next_en(m_ptr);
               m_wrap = (np <= m_ptr) ? 1 : 0;
               m_ptr = np;
               m_elapsed = 0;
            end else begin
               if (ld) m_valid = 0;
               if (done && !ch_en[m_ptr] && ch_en != 0) begin
                  m_ptr = next_en(m_ptr);
                  m_elapsed = 0;
               end else if (!done) begin
                  m_elapsed++;
               end
            end
         end else if (ms == 0) begin
            if (ld) begin
               m_data = word(sel);
               m_ch = sel;
               m_valid = ch_en[sel] ? 1 : 0;
               if (m_valid == 1) exp_q.push_back('{m_data, m_ch});
            end
         end else if (ld) begin
            m_valid = 0;
         end
         m_prev = ms;
      end
   end

   // Monitor: per-cycle handshake flags against the model, accepted beats against the queue.
   always @(negedge clk) begin
      if (mon_on) begin
         check("valid", out_valid, m_valid);
         check("wrap", wrap, m_wrap);
         if (wrap) wrap_cnt++;
         if (out_valid && out_ready && !rst) begin
            if (exp_q.size() == 0) begin
               check("sb_pending", exp_q.size(), 1);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               check("sb_data", out_data, e.data);
               check("sb_ch", out_ch, e.ch);
               seen_ch.push_back(out_ch);
               seen_cyc.push_back(cyc);
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_seen();
      seen_ch.delete();
      seen_cyc.delete();
      wrap_cnt = 0;
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_data"}, out_data, 0);
      check({name, "_ch"}, out_ch, 0);
      check({name, "_valid"}, out_valid, 0);
      check({name, "_wrap"}, wrap, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int d, c;
      int exp3[5];
      int exp4[3];
      exp3 = '{0, 1, 2, 3, 0};
      exp4 = '{1, 3, 1};

      // Reset, then MANUAL capture of channel 2.
      rst = 1; in_data = 32'hDDCCBBAA; ch_en = 4'hF; mode = 2'b00; sel = 0; out_ready = 1;
      tick(2);
      mon_on = 1;
      check_all_zero("rst");
      rst = 0; sel = 2;
      tick();
      check("m_sel2_data", out_data, 8'hCC);
      check("m_sel2_ch", out_ch, 2);
      check("m_sel2_valid", out_valid, 1);

      // Disabled channel is never issued.
      sel = 1; ch_en = 4'b1101;
      tick();
      check("m_dis_valid", out_valid, 0);
      sel = 3;
      tick();
      check("m_sel3_data", out_data, 8'hDD);
      check("m_sel3_valid", out_valid, 1);

      // SCAN over all channels.
      ch_en = 4'hF; mode = 2'b01;
      tick();
      clear_seen();
      tick(21);
      check("p3_beats", seen_ch.size() >= 5, 1);
      for (int i = 0; i < 5 && i < seen_ch.size(); i++) begin
         check("p3_ch", seen_ch[i], exp3[i]);
         if (i > 0) check("p3_gap", seen_cyc[i] - seen_cyc[i-1], DWELL);
      end
      check("p3_wraps", wrap_cnt, 1);

      // SCAN over channels 1 and 3.
      mode = 2'b00;
      tick();
      ch_en = 4'b1010; mode = 2'b01;
      tick();
      clear_seen();
      tick(13);
      check("p4_beats", seen_ch.size() >= 3, 1);
      for (int i = 0; i < 3 && i < seen_ch.size(); i++) check("p4_ch", seen_ch[i], exp4[i]);
      check("p4_wraps", wrap_cnt, 1);

      // Stall with changing inputs, then release.
      ch_en = 4'hF; out_ready = 0;
      for (int i = 0; i < 10 && !out_valid; i++) tick();
      check("p5_wait", out_valid, 1);
      d = out_data; c = out_ch;
      for (int i = 0; i < 10; i++) begin
         in_data = $urandom;
         tick();
         check("p5_hold_data", out_data, d);
         check("p5_hold_ch", out_ch, c);
         check("p5_hold_valid", out_valid, 1);
      end
      out_ready = 1;
      tick();
      check("p5_next_valid", out_valid, 1);
      check("p5_next_ch", out_ch, (c + 1) % NCH);

      // All channels disabled.
      ch_en = 4'h0;
      tick(2);
      wrap_cnt = 0;
      tick(10);
      check("p6_valid", out_valid, 0);
      check("p6_wraps", wrap_cnt, 0);

      // Reset in the middle of a stall.
      ch_en = 4'hF; out_ready = 0;
      for (int i = 0; i < 10 && !out_valid; i++) tick();
      check("p6_stall", out_valid, 1);
      rst = 1;
      tick();
      check_all_zero("p6_rst");
      rst = 0; mode = 2'b00; sel = 0; out_ready = 1;
      tick();
      check("p6_manual_valid", out_valid, 1);
      check("p6_manual_ch", out_ch, 0);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         in_data   = $urandom;
         out_ready = ($urandom_range(3) != 0);
         sel       = SELW'($urandom_range(NCH - 1));
         if ($urandom_range(15) == 0) mode  = 2'($urandom_range(3));
         if ($urandom_range(31) == 0) ch_en = NCH'($urandom_range((1 << NCH) - 1));
         rst = ($urandom_range(199) == 0);
         tick();
      end

      rst = 0; mode = 2'b10; out_ready = 1;
      tick(3);
      check("sb_drain", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
